// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer that lets two requesters share one
// synchronous 16 x 8 RAM port, producing a single-cycle write strobe per access.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_busy;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data_in;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_any_req;
    logic              w_pick1;
    logic              w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    // Port 1 wins when it is alone, or when both ask and port 0 was served last.
    assign w_any_req   = req0 | req1;
    assign w_pick1     = req1 & (~req0 | ~r_last);
    assign w_we_sel    = w_pick1 ? we1    : we0;
    assign w_addr_sel  = w_pick1 ? addr1  : addr0;
    assign w_wdata_sel = w_pick1 ? wdata1 : wdata0;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_port        <= 1'b0;
            r_we          <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_busy        <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data_in <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_port        <= w_pick1;
                        r_last        <= w_pick1;
                        r_we          <= w_we_sel;
                        r_ram_we      <= w_we_sel;
                        r_ram_address <= w_addr_sel;
                        r_ram_data_in <= w_wdata_sel;
                        r_gnt0        <= ~w_pick1;
                        r_gnt1        <= w_pick1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // The RAM captures the command at this edge; the strobe ends here.
                    r_ram_we <= 1'b0;
                    if (r_we) begin
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_port) begin
                        r_rdata1 <= ram_data_out;
                    end else begin
                        r_rdata0 <= ram_data_out;
                    end
                    r_done0 <= ~r_port;
                    r_done1 <= r_port;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign busy        = r_busy;
    assign ram_we      = r_ram_we;
    assign ram_address = r_ram_address;
    assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16 x 8 synchronous RAM
// attached to the arbiter's RAM port.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, done0, done1, busy, ram_we;
    logic [7:0] rdata0, rdata1;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [16] = '{default: 8'h00};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .done0        (done0),
        .done1        (done1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .busy         (busy),
        .ram_we       (ram_we),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    // Raise a request on one port, drop it once granted, wait for done, return in IDLE.
    task automatic do_txn(input int port, input logic we, input logic [3:0] addr,
                          input logic [7:0] wd);
        logic seen;
        if (port == 0) begin
            we0 = we; addr0 = addr; wdata0 = wd; req0 = 1'b1;
        end else begin
            we1 = we; addr1 = addr; wdata1 = wd; req1 = 1'b1;
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = (port == 0) ? gnt0 : gnt1;
        end
        check("txn_grant", seen, 1);
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (port == 0) ? done0 : done1;
        end
        check("txn_done", seen, 1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g_order[6];
        int ngrant, ndone;
        logic p0, p1, ovl;

        // Reset state
        #2;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_address, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        apply_reset();

        // Single write 0xAB to 0x3, port 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hAB;
        tick();
        check("wr_gnt0", gnt0, 1);
        check("wr_ram_we_hi", ram_we, 1);
        check("wr_ram_addr", ram_address, 4'h3);
        check("wr_ram_din", ram_data_in, 8'hAB);
        check("wr_busy", busy, 1);
        check("wr_done0_early", done0, 0);
        req0 = 1'b0;
        tick();
        check("wr_ram_we_lo", ram_we, 0);
        check("wr_done0", done0, 1);
        check("wr_gnt0_done", gnt0, 1);
        tick();
        check("wr_done0_clr", done0, 0);
        check("wr_gnt0_clr", gnt0, 0);
        check("wr_busy_clr", busy, 0);

        // Read back 0x3, port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
        tick();
        check("rd_gnt0", gnt0, 1);
        check("rd_ram_we", ram_we, 0);
        req0 = 1'b0;
        tick();
        check("rd_done0_read", done0, 0);
        tick();
        check("rd_done0", done0, 1);
        check("rd_rdata0", rdata0, 8'hAB);
        tick();
        check("rd_idle", busy, 0);

        // Contention from reset: port 0 writes 0xCD to 0xA, port 1 reads 0xA
        apply_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'hA; wdata0 = 8'hCD;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'hA;
        tick();
        check("ct_gnt0", gnt0, 1);
        check("ct_gnt1_wait", gnt1, 0);
        req0 = 1'b0;
        tick();
        check("ct_done0", done0, 1);
        tick();
        check("ct_idle_gnt1", gnt1, 0);
        tick();
        check("ct_gnt1", gnt1, 1);
        req1 = 1'b0;
        repeat (2) tick();
        check("ct_done1", done1, 1);
        check("ct_rdata1", rdata1, 8'hCD);
        check("ct_rdata0", rdata0, 8'h00);
        tick();

        // Round-robin under saturation: six reads, both requests held
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'hA;
        for (int i = 0; i < 6; i++) g_order[i] = 9;
        ngrant = 0; ndone = 0; p0 = 1'b0; p1 = 1'b0; ovl = 1'b0;
        for (int c = 0; c < 80 && ndone < 6; c++) begin
            tick();
            if (gnt0 && gnt1) ovl = 1'b1;
            if (gnt0 && !p0 && ngrant < 6) begin g_order[ngrant] = 0; ngrant++; end
            if (gnt1 && !p1 && ngrant < 6) begin g_order[ngrant] = 1; ngrant++; end
            p0 = gnt0;
            p1 = gnt1;
            if (done0 || done1) ndone++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_done_count", ndone, 6);
        check("rr_grant_count", ngrant, 6);
        check("rr_no_overlap", ovl, 0);
        for (int i = 0; i < 6; i++) check($sformatf("rr_order%0d", i), g_order[i], i % 2);
        check("rr_rdata0", rdata0, 8'hAB);
        check("rr_rdata1", rdata1, 8'hCD);
        repeat (2) tick();
        check("rr_idle", busy, 0);

        // Port isolation
        do_txn(0, 1'b1, 4'h5, 8'h11);
        do_txn(1, 1'b1, 4'h6, 8'h22);
        do_txn(1, 1'b0, 4'h5, 8'h00);
        check("iso_rdata1", rdata1, 8'h11);
        do_txn(0, 1'b0, 4'h6, 8'h00);
        check("iso_rdata0", rdata0, 8'h22);
        check("iso_rdata1_kept", rdata1, 8'h11);

        // Reset mid-write: 0x77 to 0x2 aborted, previous 0x55 survives
        do_txn(0, 1'b1, 4'h2, 8'h55);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'h77;
        tick();
        check("mr_ram_we_hi", ram_we, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_ram_we_drop", ram_we, 0);
        check("mr_gnt0", gnt0, 0);
        check("mr_busy", busy, 0);
        check("mr_done0", done0, 0);
        check("mr_ram_addr", ram_address, 0);
        check("mr_ram_din", ram_data_in, 0);
        check("mr_rdata0", rdata0, 0);
        check("mr_rdata1", rdata1, 0);
        req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mr_no_done", done0, 0);
        end
        reset_n = 1'b1;
        do_txn(0, 1'b0, 4'h2, 8'h00);
        check("mr_rdata_kept", rdata0, 8'h55);

        // Late request: req1 rises while port 0 is in READ
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h5;
        tick();
        check("lr_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h6;
        tick();
        check("lr_done0", done0, 1);
        check("lr_gnt1_wait_done", gnt1, 0);
        check("lr_rdata0", rdata0, 8'h11);
        tick();
        check("lr_gnt1_wait_idle", gnt1, 0);
        check("lr_idle", busy, 0);
        tick();
        check("lr_gnt1", gnt1, 1);
        req1 = 1'b0;
        repeat (2) tick();
        check("lr_done1", done1, 1);
        check("lr_rdata1", rdata1, 8'h22);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the shared 16 x 8 synchronous RAM. It lets two requesters (port 0: program loader, port 1: CPU memory path) share the single RAM port. It serialises their reads and writes with round-robin fairness and generates the single-cycle `ram_we` strobe. It sits between the requesters and the `ram` instance, which writes on a rising edge when `we` is high and updates its registered `data_out` on the rising edge that samples `address`.

## Interface
- `ADDR_W`, 4, RAM address width (16 words)
- `DATA_W`, 8, RAM data width
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  access request, level, per port
- `we0` / `we1`  in  1  1 = write, 0 = read; held stable while `reqN` is high
- `addr0` / `addr1`  in  ADDR_W  word address; held stable while `reqN` is high
- `wdata0` / `wdata1`  in  DATA_W  write data; held stable while `reqN` is high
- `gnt0` / `gnt1`  out  1  port owns the RAM (ACCESS through DONE)
- `done0` / `done1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  last read result for that port
- `busy`  out  1  state != IDLE
- `ram_we`  out  1  to `ram.we`
- `ram_address`  out  ADDR_W  to `ram.address`
- `ram_data_in`  out  DATA_W  to `ram.data_in`
- `ram_data_out`  in  DATA_W  from `ram.data_out`

## Operation
- FSM states: IDLE, ACCESS, READ, DONE. All outputs are registered.
- IDLE: at a rising edge with any `reqN` high, the FSM picks a winner.
  - Latch the winner's `we`, `addr` and `wdata`.
  - Drive `ram_address` and `ram_data_in` from the latched values.
  - Set `ram_we` to the latched `we`.
  - Assert `gntN` and go to ACCESS.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: the port not served last wins.
  - `last` resets to 1, so port 0 wins the first contention.
  - `last` updates when the grant is issued.
- ACCESS: the RAM samples the command at the closing edge.
  - `ram_we` clears at that edge, so it is high for exactly one cycle.
  - Write: go to DONE.
  - Read: go to READ.
- READ: `ram_data_out` is valid. At the closing edge, latch it into `rdataN` of the granted port and go to DONE.
- DONE: `doneN` is high for this one cycle and `gntN` stays high. At the closing edge, clear `gntN` and `doneN` and return to IDLE.
- `rdataN` holds its value until the next completed read on that same port. Writes never alter `rdata`.
- Requests are not sampled outside IDLE. A request rising mid-transaction waits.
- If `reqN` is still high in the IDLE cycle after DONE, it is a new request. Round-robin gives the other port priority if it is waiting.
- Requests are not cancellable. Dropping `reqN` after the grant does not abort the transaction; it completes and pulses `done`.
- `ram_address` and `ram_data_in` hold their last values in IDLE. Only `ram_we` gates the RAM.

## Timing
- Reset (asynchronous, immediate on `reset_n` low):
  - State goes to IDLE; `last` goes to 1.
  - All `gnt`, `done`, `busy` and `ram_we` outputs go to 0.
  - `ram_address`, `ram_data_in`, `rdata0` and `rdata1` go to 0.
  - A transaction cut by reset produces no `done` pulse. If `ram_we` was high, it drops without waiting for a clock edge.
- Write latency: request sampled at edge E; `ram_we` high in cycle E..E+1; `done` high in cycle E+1..E+2. Minimum 3 cycles per write including IDLE.
- Read latency: sampled at E; ACCESS E..E+1; READ E+1..E+2; `done` and valid `rdata` from E+2. Minimum 4 cycles per read.
- `gntN` is high from E through the end of DONE. `gnt0 & gnt1` is never 1.
- Back-to-back contention: a saturated pair alternates grants 0,1,0,1. No port waits more than one foreign transaction.

## Test plan
- Single write then read, port 0: write 0xAB to address 0x3, then read 0x3.
  - `ram_we` is high for exactly 1 cycle.
  - `done0` pulses 2 cycles after the write request is sampled.
  - `rdata0` = 0xAB with `done0`, 3 cycles after the read request is sampled.
- Contention from reset: `req0` and `req1` rise on the same edge, port 0 writing 0xCD to 0xA and port 1 reading 0xA.
  - Port 0 is granted first.
  - Port 1 is granted in the following IDLE and returns `rdata1` = 0xCD.
  - `rdata0` is unchanged (0x00).
- Round-robin under saturation: both ports hold `req` for 6 transactions.
  - Grant order is 0,1,0,1,0,1.
  - `gnt0` and `gnt1` are never high together.
- Port isolation: port 1 reads 0x5 (pre-written 0x11), then port 0 reads 0x6 (0x22).
  - `rdata1` stays 0x11 after port 0 completes.
  - `rdata0` = 0x22.
- Reset mid-write: assert `reset_n` low during ACCESS of a write of 0x77 to 0x2.
  - `ram_we` drops immediately; all outputs are 0; no `done` pulse.
  - A subsequent read of 0x2 shows the pre-reset contents.
- Late request: `req1` rises while port 0 is in READ.
  - `req1` is not granted until port 0's DONE completes.
  - `gnt1` asserts at the first IDLE edge afterwards.
